fifo_wptr_full: RTL and testbench



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_gray_cnt.sv | 30 +++
 rtl/fifo_wptr_full.sv | 77 +++++++
 tb/tb_fifo_wptr_full.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks: default sizing and Gray-code helpers.
// Helpers work on 32-bit zero-extended values; callers cast to their pointer width.
package fifo_pkg;

   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DEPTH          = 2**ADDR_WIDTH_DEF;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) b = b ^ (g >> i);
      return b;
   endfunction

endpackage

// File: rtl/fifo_gray_cnt.sv
// Binary/Gray register pair with increment enable; shared by the write and read pointer blocks.
module fifo_gray_cnt
   import fifo_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] bin,
   output logic [W-1:0] binnext,
   output logic [W-1:0] graynext,
   output logic [W-1:0] gray
);

   assign binnext  = bin + W'(inc);
   assign graynext = W'(bin2gray(32'(binnext)));

   // gray is driven straight from a flop so the synchronizer never sees a glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin  <= '0;
         gray <= '0;
      end else begin
         bin  <= binnext;
         gray <= graynext;
      end
   end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and registered, pessimistic full flag for the async FIFO.
// Define FIFO_AFULL_EN to build the almost-full flag; otherwise walmost_full is tied low.
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH   = fifo_pkg::ADDR_WIDTH_DEF,
   parameter int AFULL_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic                  wfull,
   output logic                  wovf,
   output logic                  walmost_full
);

   localparam int SLOTS = 2**ADDR_WIDTH;

   if (ADDR_WIDTH < 2 || AFULL_THRESH < 0 || AFULL_THRESH > SLOTS)
      $error("fifo_wptr_full: bad ADDR_WIDTH/AFULL_THRESH");

   logic [ADDR_WIDTH:0] wbin, wbinnext, wgraynext;
   logic                full_next;
   logic                unused;

   assign wen = winc & ~wfull;

   fifo_gray_cnt #(.W(ADDR_WIDTH+1)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (wen),
      .bin      (wbin),
      .binnext  (wbinnext),
      .graynext (wgraynext),
      .gray     (wptr)
   );

   assign waddr = wbin[ADDR_WIDTH-1:0];

   // Full when the writer is one lap ahead: top two Gray bits inverted, rest equal.
   assign full_next = (wgraynext == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                     wq2_rptr[ADDR_WIDTH-2:0]});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wfull <= 1'b0;
         wovf  <= 1'b0;
      end else begin
         wfull <= full_next;
         wovf  <= winc & wfull;
      end
   end

`ifdef FIFO_AFULL_EN
   localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(SLOTS - AFULL_THRESH);

   logic [ADDR_WIDTH:0] rbin, wcount;

   assign rbin   = (ADDR_WIDTH+1)'(gray2bin(32'(wq2_rptr)));
   assign wcount = wbinnext - rbin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) walmost_full <= 1'b0;
      else        walmost_full <= (wcount >= AF_LVL);
   end

   assign unused = wbin[ADDR_WIDTH];
`else
   assign walmost_full = 1'b0;
   assign unused       = ^{wbin[ADDR_WIDTH], wbinnext};
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_WIDTH=4): vector table for fill/full/overflow/release,
// plus hand sequences for async reset and a 64-write run against a lagging read pointer.
module tb_fifo_wptr_full;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       winc = 1'b0;
   logic [4:0] wq2_rptr = '0;
   logic       wen, wfull, wovf, walmost_full;
   logic [3:0] waddr;
   logic [4:0] wptr;

   int checks = 0;
   int errors = 0;

   fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .winc         (winc),
      .wq2_rptr     (wq2_rptr),
      .wen          (wen),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .wovf         (wovf),
      .walmost_full (walmost_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       winc;
      logic [4:0] rq;
      logic       wen;    // before the edge
      logic [3:0] waddr;  // after the edge
      logic [4:0] wptr;
      logic       full;
      logic       ovf;
      logic       af;
   } vec_t;

   vec_t tv[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wi, input logic [4:0] rq, input logic we,
                               input logic [3:0] wa, input logic [4:0] wp,
                               input logic fu, input logic ov, input logic af);
      vec_t v;
      v.winc = wi; v.rq = rq; v.wen = we; v.waddr = wa;
      v.wptr = wp; v.full = fu; v.ovf = ov; v.af = af;
      return v;
   endfunction

   initial begin
      logic [4:0] gseq [16];
      logic [4:0] old, q1, q2;
      logic       exp_af;

      // Gray codes of 1..16 (5-bit)
      gseq = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101, 5'b00100, 5'b01100,
               5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011, 5'b01001, 5'b01000, 5'b11000};
      for (int i = 0; i < 16; i++)
         tv[i] = mk(1'b1, 5'd0, 1'b1, 4'((i + 1) % 16), gseq[i], i == 15, 1'b0, (i + 1) >= 14);
      tv[16] = mk(1'b1, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 1'b1); // write while full
      tv[17] = mk(1'b0, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b0, 1'b1); // ovf is one pulse
      tv[18] = mk(1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b0, 1'b1); // reader freed a slot
      tv[19] = mk(1'b1, 5'b00001, 1'b1, 4'd1, 5'b11001, 1'b1, 1'b0, 1'b1); // refill
      tv[20] = mk(1'b1, 5'b00001, 1'b0, 4'd1, 5'b11001, 1'b1, 1'b1, 1'b1);
      tv[21] = mk(1'b0, 5'b00001, 1'b0, 4'd1, 5'b11001, 1'b1, 1'b0, 1'b1);

      // reset state, no clock edge yet
      #2;
      chk("rst_wptr", 32'(wptr), 0);
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_wfull", 32'(wfull), 0);
      chk("rst_wovf", 32'(wovf), 0);
      chk("rst_wen", 32'(wen), 0);
      chk("rst_afull", 32'(walmost_full), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tv[i]) begin
         winc = tv[i].winc;
         wq2_rptr = tv[i].rq;
         #1;
         chk($sformatf("v%0d_wen", i), 32'(wen), 32'(tv[i].wen));
         @(posedge clk); #1;
         chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tv[i].waddr));
         chk($sformatf("v%0d_wptr", i), 32'(wptr), 32'(tv[i].wptr));
         chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(tv[i].full));
         chk($sformatf("v%0d_wovf", i), 32'(wovf), 32'(tv[i].ovf));
`ifdef FIFO_AFULL_EN
         exp_af = tv[i].af;
`else
         exp_af = 1'b0;
`endif
         chk($sformatf("v%0d_afull", i), 32'(walmost_full), 32'(exp_af));
      end

      // async reset mid-clock from the full state
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_wptr", 32'(wptr), 0);
      chk("mid_rst_waddr", 32'(waddr), 0);
      chk("mid_rst_wfull", 32'(wfull), 0);
      chk("mid_rst_wovf", 32'(wovf), 0);
      @(negedge clk);
      winc = 1'b0;
      wq2_rptr = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 64 writes, read pointer follows wptr two cycles late
      q1 = '0; q2 = '0;
      winc = 1'b1;
      for (int k = 0; k < 64; k++) begin
         old = wptr;
         #1;
         chk($sformatf("trk%0d_wen", k), 32'(wen), 1);
         @(posedge clk); #1;
         chk($sformatf("trk%0d_hamming", k), $countones(old ^ wptr), 1);
         chk($sformatf("trk%0d_wfull", k), 32'(wfull), 0);
         if (k == 31 || k == 63) chk($sformatf("trk%0d_wrap", k), 32'(wptr), 0);
         q2 = q1; q1 = wptr; wq2_rptr = q2;
      end

      // three more writes, then reset in the middle of the burst
      repeat (3) begin @(posedge clk); #1; end
      chk("burst_wptr", 32'(wptr), 32'(5'b00010));
      #3 rst_n = 1'b0;
      #1;
      chk("burst_rst_wptr", 32'(wptr), 0);
      chk("burst_rst_waddr", 32'(waddr), 0);
      @(posedge clk); #1;
      chk("burst_rst_hold", 32'(wptr), 0);
      winc = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(wptr), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
